// File: rtl/sm_seq_multiplier.sv
// Sequential sign-magnitude multiplier: one multiplier bit per clock through a shift-add
// accumulator, under a start/busy/done handshake, with a registered product and zero flag.
module sm_seq_multiplier #(
    parameter int unsigned MAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [MAG_W:0]     a_i,
    input  logic [MAG_W:0]     b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*MAG_W:0]   product_o,
    output logic               zero_flag_o
);

    localparam int unsigned ACC_W  = 2 * MAG_W;
    localparam int unsigned PROD_W = ACC_W + 1;
    localparam int unsigned CNT_W  = (MAG_W > 2) ? $clog2(MAG_W) : 1;
    localparam int unsigned LAST   = MAG_W - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [MAG_W-1:0]    a_q, a_d;
    logic [MAG_W-1:0]    b_q, b_d;
    logic                sign_q, sign_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic                zero_q, zero_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ACC_W-1:0]    addend;
    logic [ACC_W-1:0]    acc_sum;

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            zero_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic and one shift-add step per RUN cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        zero_d  = zero_q;
        addend  = b_q[cnt_q] ? (ACC_W'(a_q) << cnt_q) : '0;
        acc_sum = acc_q + addend;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    a_d     = a_i[MAG_W-1:0];
                    b_d     = b_i[MAG_W-1:0];
                    sign_d  = a_i[MAG_W] ^ b_i[MAG_W];
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_W'(1);
                // Final step writes straight to the outputs; a zero magnitude forces a positive sign.
                if (cnt_q == CNT_W'(LAST)) begin
                    state_d = S_DONE;
                    zero_d  = (acc_sum == '0);
                    prod_d  = {sign_q & (acc_sum != '0), acc_sum};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign product_o   = prod_q;
    assign zero_flag_o = zero_q;

endmodule

// File: tb/tb_sm_seq_multiplier.sv
// Bench for sm_seq_multiplier: MAG_W=4 and MAG_W=2 instances checked every cycle against a
// cycle-phase model plus hand-computed product literals.
module tb_sm_seq_multiplier;

    localparam int W4 = 4;
    localparam int W2 = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start2;
    logic [4:0] a4, b4;
    logic [2:0] a2, b2;
    logic       busy4, done4, zero4;
    logic       busy2, done2, zero2;
    logic [8:0] prod4;
    logic [4:0] prod2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sm_seq_multiplier #(.MAG_W(W4)) dut4 (
        .clk(clk), .rst(rst), .start_i(start4), .a_i(a4), .b_i(b4),
        .busy_o(busy4), .done_o(done4), .product_o(prod4), .zero_flag_o(zero4)
    );

    sm_seq_multiplier #(.MAG_W(W2)) dut2 (
        .clk(clk), .rst(rst), .start_i(start2), .a_i(a2), .b_i(b2),
        .busy_o(busy2), .done_o(done2), .product_o(prod2), .zero_flag_o(zero2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sign-magnitude product from plain integer arithmetic; zero magnitude is always positive.
    function automatic logic [63:0] smul(input int w, input int a, input int b);
        int ma, mb, mag, s;
        ma  = a % (1 << w);
        mb  = b % (1 << w);
        mag = ma * mb;
        s   = (((a >> w) & 1) ^ ((b >> w) & 1)) & ((mag != 0) ? 1 : 0);
        return (64'(s) << (2 * w)) | 64'(mag);
    endfunction

    // Model: phase 0 idle, 1..W busy, W+1 done; product updated on entering the done phase.
    int ph4 = 0, ph2 = 0, la4 = 0, lb4 = 0, la2 = 0, lb2 = 0;
    logic [63:0] ep4 = 0, ep2 = 0;
    bit ez4 = 1'b1, ez2 = 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            ph4 = 0; ep4 = 0; ez4 = 1'b1;
            ph2 = 0; ep2 = 0; ez2 = 1'b1;
        end else begin
            if (ph4 == 0) begin
                if (start4 === 1'b1) begin ph4 = 1; la4 = int'(a4); lb4 = int'(b4); end
            end else if (ph4 < W4) ph4++;
            else if (ph4 == W4) begin
                ph4++; ep4 = smul(W4, la4, lb4); ez4 = ((la4 % 16) * (lb4 % 16)) == 0;
            end else ph4 = 0;

            if (ph2 == 0) begin
                if (start2 === 1'b1) begin ph2 = 1; la2 = int'(a2); lb2 = int'(b2); end
            end else if (ph2 < W2) ph2++;
            else if (ph2 == W2) begin
                ph2++; ep2 = smul(W2, la2, lb2); ez2 = ((la2 % 4) * (lb2 % 4)) == 0;
            end else ph2 = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy4", 64'(busy4), 64'(ph4 >= 1 && ph4 <= W4));
            chk("done4", 64'(done4), 64'(ph4 == W4 + 1));
            chk("prod4", 64'(prod4), ep4);
            chk("zero4", 64'(zero4), 64'(ez4));
            chk("busy2", 64'(busy2), 64'(ph2 >= 1 && ph2 <= W2));
            chk("done2", 64'(done2), 64'(ph2 == W2 + 1));
            chk("prod2", 64'(prod2), ep2);
            chk("zero2", 64'(zero2), 64'(ez2));
        end
    end

    task automatic go4(input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        start4 = 1'b1; a4 = a; b4 = b;
        @(negedge clk);
        start4 = 1'b0; a4 = 5'h1f; b4 = 5'h1f;
    endtask

    task automatic go2(input logic [2:0] a, input logic [2:0] b);
        @(negedge clk);
        start2 = 1'b1; a2 = a; b2 = b;
        @(negedge clk);
        start2 = 1'b0; a2 = 3'h7; b2 = 3'h7;
    endtask

    task automatic wait4(output int nbusy);
        bit ok = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            if (done4) begin ok = 1'b1; break; end
            if (busy4) nbusy++;
            @(negedge clk);
        end
        if (!ok) chk("timeout4", 64'(0), 64'(1));
    endtask

    task automatic wait2(output int nbusy);
        bit ok = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            if (done2) begin ok = 1'b1; break; end
            if (busy2) nbusy++;
            @(negedge clk);
        end
        if (!ok) chk("timeout2", 64'(0), 64'(1));
    endtask

    initial begin
        int nb;
        int ndone;
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_prod4", 64'(prod4), 64'(0));
        chk("rst_zero4", 64'(zero4), 64'(1));
        chk("rst_busy4", 64'(busy4), 64'(0));
        chk("rst_done4", 64'(done4), 64'(0));
        chk("rst_prod2", 64'(prod2), 64'(0));
        chk("rst_zero2", 64'(zero2), 64'(1));
        chk_en = 1'b1;
        rst = 1'b0;

        // +5 x -3 = -15
        go4(5'b0_0101, 5'b1_0011);
        wait4(nb);
        chk("basic_busy_cycles", 64'(nb), 64'(4));
        chk("basic_prod", 64'(prod4), 64'(9'b1_0000_1111));
        chk("basic_zero", 64'(zero4), 64'(0));

        // 15 x 15 = 225
        go4(5'b0_1111, 5'b0_1111);
        wait4(nb);
        chk("full_prod", 64'(prod4), 64'(9'b0_1110_0001));
        chk("full_zero", 64'(zero4), 64'(0));

        // -0 x -7: zero with positive sign
        go4(5'b1_0000, 5'b1_0111);
        wait4(nb);
        chk("zero_prod", 64'(prod4), 64'(9'b0_0000_0000));
        chk("zero_flag", 64'(zero4), 64'(1));

        // start held through RUN and DONE with different operands is ignored
        @(negedge clk);
        start4 = 1'b1; a4 = 5'd3; b4 = 5'd2;
        @(negedge clk);
        a4 = 5'd7; b4 = 5'd7;
        wait4(nb);
        chk("ignore_prod", 64'(prod4), 64'(6));
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ignore_idle", 64'(busy4), 64'(0));
        go4(5'd7, 5'd7);
        wait4(nb);
        chk("fresh_prod", 64'(prod4), 64'(49));

        // reset in the 2nd RUN cycle discards +9 x +9
        go4(5'd9, 5'd9);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(busy4), 64'(0));
        chk("midrst_done", 64'(done4), 64'(0));
        chk("midrst_prod", 64'(prod4), 64'(0));
        chk("midrst_zero", 64'(zero4), 64'(1));
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done4) ndone++;
        end
        chk("midrst_nodone", 64'(ndone), 64'(0));
        go4(5'd9, 5'd9);
        wait4(nb);
        chk("after_rst_prod", 64'(prod4), 64'(81));

        // back-to-back held start: second op accepted in the first IDLE cycle
        @(negedge clk);
        start4 = 1'b1; a4 = 5'd2; b4 = 5'd3;
        @(negedge clk);
        wait4(nb);
        chk("b2b_first", 64'(prod4), 64'(6));
        a4 = 5'b1_0011; b4 = 5'd3;
        @(negedge clk);
        @(negedge clk);
        start4 = 1'b0;
        wait4(nb);
        chk("b2b_second", 64'(prod4), 64'(9'b1_0000_1001));

        // MAG_W=2: -3 x +3 = -9
        go2(3'b111, 3'b011);
        wait2(nb);
        chk("w2_busy_cycles", 64'(nb), 64'(2));
        chk("w2_prod", 64'(prod2), 64'(5'b1_1001));

        for (int ai = 0; ai < 8; ai++) begin
            for (int bi = 0; bi < 8; bi++) begin
                go2(3'(ai), 3'(bi));
                wait2(nb);
                chk("w2_sweep", 64'(prod2), smul(W2, ai, bi));
            end
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
